// File: rtl/ram_wr_pkg.sv
// Shared types and constant helpers for the packet-to-RAM write controller.
package ram_wr_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_e;

    localparam int unsigned ERR_SOP   = 0;
    localparam int unsigned ERR_SHORT = 1;
    localparam int unsigned ERR_LONG  = 2;

    // Counter width for values 0..v-1, never narrower than one bit
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) r++;
        return (r == 0) ? 1 : r;
    endfunction

    function automatic int unsigned words_per_row(input int unsigned k, input int unsigned elem_w,
                                                  input int unsigned data_w);
        return (k * elem_w + data_w - 1) / data_w;
    endfunction

    // Strobe of the final word of a row; partial when K does not fill it
    function automatic int unsigned last_strb(input int unsigned k, input int unsigned strb_w);
        int unsigned rem;
        rem = k % strb_w;
        return (rem == 0) ? ((32'd1 << strb_w) - 1) : ((32'd1 << rem) - 1);
    endfunction

endpackage

// File: rtl/ram_wr_ctrl_gen_if.sv
// Bus receive side and RAM write side of the write controller.
// RAM_WR_PINGPONG_EN adds the ram_wr_bank output.
interface ram_wr_ctrl_gen_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned STRB_W = 2,
    parameter int unsigned ADDR_W = 4
);
    logic              frame_clr;
    logic              wr_sop;
    logic              wr_eop;
    logic              wr_vld;
    logic [DATA_W-1:0] wr_data;
    logic              ram_wr_en;
    logic [STRB_W-1:0] ram_wr_strb;
    logic [ADDR_W-1:0] ram_wr_addr;
    logic [DATA_W-1:0] ram_wr_data;
    logic              frame_done;
    logic [2:0]        err_pulse;
`ifdef RAM_WR_PINGPONG_EN
    logic              ram_wr_bank;
`endif

    modport master (
        output frame_clr, wr_sop, wr_eop, wr_vld, wr_data,
        input  ram_wr_en, ram_wr_strb, ram_wr_addr, ram_wr_data, frame_done, err_pulse
`ifdef RAM_WR_PINGPONG_EN
        , input ram_wr_bank
`endif
    );

    modport slave (
        input  frame_clr, wr_sop, wr_eop, wr_vld, wr_data,
        output ram_wr_en, ram_wr_strb, ram_wr_addr, ram_wr_data, frame_done, err_pulse
`ifdef RAM_WR_PINGPONG_EN
        , output ram_wr_bank
`endif
    );
endinterface

// File: rtl/ram_wr_addr_gen.sv
// Row / word-index counters and the arithmetic (row, widx) -> (addr, strb) mapping.
module ram_wr_addr_gen
    import ram_wr_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ELEM_W    = 16,
    parameter int unsigned STRB_W    = 2,
    parameter int unsigned K         = 3,
    parameter int unsigned ROWS      = 3,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned ROW_PITCH = 3,
    parameter int unsigned ADDR_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              restart,
    input  logic              wr,
    input  logic              pkt_end,
    input  logic              row_adv,
    output logic [ADDR_W-1:0] addr_c,
    output logic [STRB_W-1:0] strb_c,
    output logic              avail_c,
    output logic              last_c,
    output logic              full_c,
    output logic              row_last_c
);
    localparam int unsigned WPR    = words_per_row(K, ELEM_W, DATA_W);
    localparam int unsigned WIDX_W = clog2(WPR + 1);
    localparam int unsigned ROW_W  = clog2(ROWS);
    localparam int unsigned LSTRB  = last_strb(K, STRB_W);

    logic [ROW_W-1:0]  row_q;
    logic [WIDX_W-1:0] widx_q;
    logic [WIDX_W-1:0] widx_eff;

    // A sop beat always addresses word 0 of the row, even on a restart
    always_comb begin
        widx_eff   = restart ? '0 : widx_q;
        avail_c    = widx_eff < WIDX_W'(WPR);
        last_c     = widx_eff == WIDX_W'(WPR - 1);
        full_c     = widx_eff == WIDX_W'(WPR);
        row_last_c = row_q == ROW_W'(ROWS - 1);
        addr_c     = ADDR_W'(BASE_ADDR + 32'(row_q) * ROW_PITCH + 32'(widx_eff) * STRB_W);
        strb_c     = last_c ? STRB_W'(LSTRB) : '1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q  <= '0;
            widx_q <= '0;
        end else if (clr) begin
            row_q  <= '0;
            widx_q <= '0;
        end else begin
            if (row_adv) row_q <= row_last_c ? '0 : row_q + ROW_W'(1);
            widx_q <= pkt_end ? '0 : widx_eff + WIDX_W'(wr);
        end
    end
endmodule

// File: rtl/ram_wr_ctrl_gen.sv
// Packet-to-RAM write controller: picks masked beats and emits one element-addressed RAM write each.
// RAM_WR_PINGPONG_EN adds a frame-toggled ram_wr_bank output.
module ram_wr_ctrl_gen
    import ram_wr_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ELEM_W    = 16,
    parameter int unsigned K         = 3,
    parameter int unsigned ROWS      = 3,
    parameter int unsigned BEATS     = 10,
    parameter logic [BEATS-1:0] VLD_MASK = 10'b0000000110,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned ROW_PITCH = 3,
    parameter int unsigned ADDR_W    = 4
) (
    input  logic clk,
    input  logic rst,
    ram_wr_ctrl_gen_if.slave bus
);
    localparam int unsigned STRB_W = DATA_W / ELEM_W;
    // One extra code so the counter can sit at BEATS once a packet overruns
    localparam int unsigned BEAT_W = clog2(BEATS + 1);
    localparam logic [2**BEAT_W-1:0] MASK_EXT = (2**BEAT_W)'(VLD_MASK);

    if (BASE_ADDR + (ROWS - 1) * ROW_PITCH + K - 1 >= (32'd1 << ADDR_W)) begin : g_addr_chk
        $error("ram_wr_ctrl_gen: address range exceeds ADDR_W");
    end

    state_e            state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d, beat_i;
    logic              long_q, long_d;
    logic              sop_beat, in_pkt, beat_ok, wr, eop_evt, full_after, row_adv, fd;
    logic [2:0]        err_d;
    logic [ADDR_W-1:0] addr_c;
    logic [STRB_W-1:0] strb_c;
    logic              avail_c, last_c, full_c, row_last_c;

    ram_wr_addr_gen #(
        .DATA_W(DATA_W), .ELEM_W(ELEM_W), .STRB_W(STRB_W), .K(K), .ROWS(ROWS),
        .BASE_ADDR(BASE_ADDR), .ROW_PITCH(ROW_PITCH), .ADDR_W(ADDR_W)
    ) u_addr_gen (
        .clk(clk), .rst(rst), .clr(bus.frame_clr), .restart(sop_beat), .wr(wr),
        .pkt_end(eop_evt), .row_adv(row_adv), .addr_c(addr_c), .strb_c(strb_c),
        .avail_c(avail_c), .last_c(last_c), .full_c(full_c), .row_last_c(row_last_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.frame_clr)  state_d = IDLE;
        else if (in_pkt)    state_d = bus.wr_eop ? IDLE : RECV;
    end

    // Beat decode; frame_clr masks every event of its cycle
    always_comb begin
        err_d      = '0;
        sop_beat   = bus.wr_vld && bus.wr_sop;
        in_pkt     = bus.wr_vld && (bus.wr_sop || state_q == RECV);
        beat_i     = sop_beat ? '0 : beat_q;
        beat_ok    = in_pkt && (beat_i < BEAT_W'(BEATS)) && MASK_EXT[beat_i];
        wr         = beat_ok && avail_c && !bus.frame_clr;
        eop_evt    = in_pkt && bus.wr_eop && !bus.frame_clr;
        full_after = full_c || (wr && last_c);
        row_adv    = eop_evt && full_after;
        fd         = wr && last_c && row_last_c;
        err_d[ERR_SHORT] = eop_evt && !full_after;
        err_d[ERR_SOP]   = sop_beat && (state_q == RECV) && !bus.frame_clr;
        err_d[ERR_LONG]  = in_pkt && !bus.frame_clr && !bus.wr_eop && !long_q
                           && (beat_i == BEAT_W'(BEATS));
        beat_d = beat_q;
        long_d = long_q;
        if (bus.frame_clr) begin
            beat_d = '0;
            long_d = 1'b0;
        end else if (in_pkt) begin
            beat_d = bus.wr_eop ? '0
                   : (beat_i < BEAT_W'(BEATS)) ? beat_i + BEAT_W'(1) : beat_i;
            long_d = bus.wr_eop ? 1'b0 : ((long_q && !sop_beat) || err_d[ERR_LONG]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_q           <= '0;
            long_q           <= 1'b0;
            bus.ram_wr_en    <= 1'b0;
            bus.ram_wr_strb  <= '0;
            bus.ram_wr_addr  <= '0;
            bus.ram_wr_data  <= '0;
            bus.frame_done   <= 1'b0;
            bus.err_pulse    <= '0;
        end else begin
            beat_q           <= beat_d;
            long_q           <= long_d;
            bus.ram_wr_en    <= wr;
            bus.ram_wr_strb  <= wr ? strb_c : '0;
            bus.ram_wr_addr  <= wr ? addr_c : '0;
            bus.ram_wr_data  <= wr ? bus.wr_data : '0;
            bus.frame_done   <= fd;
            bus.err_pulse    <= err_d;
        end
    end

`ifdef RAM_WR_PINGPONG_EN
    logic bank_q;

    // Bank flips when the last row of a frame closes with its eop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_q          <= 1'b0;
            bus.ram_wr_bank <= 1'b0;
        end else begin
            if (bus.frame_clr)               bank_q <= 1'b0;
            else if (row_adv && row_last_c)  bank_q <= ~bank_q;
            bus.ram_wr_bank <= wr ? bank_q : 1'b0;
        end
    end
`endif
endmodule
